// File: rtl/switchbox_cfg.sv
// switchbox_cfg: programmable routing switch box with a serial configuration path.
//
// Every pin on the four sides (top, right, bottom, left) either floats or copies
// another pin, according to an entry in the active routing register. Entries are
// loaded serially into a shadow register. On commit, the shadow is checked one
// entry per cycle. If every entry is legal it is copied to the active register;
// otherwise the active routing is left as it was and the first error is reported.
//
// Ports:
//   clk, rst_n     fabric clock, asynchronous active-low reset
//   route_en       global drive enable (0 = every pin floats)
//   cfg_shift/din  shift one configuration bit in (enters at the MSB)
//   cfg_dout       shadow bit 0, for daisy-chaining and readback
//   cfg_commit     request validate-and-apply of the shadow register
//   cfg_busy       high while checking or applying
//   cfg_done       one-cycle pulse: new routing applied
//   cfg_err        one-cycle pulse: configuration rejected
//   cfg_err_code   reason for the last rejection (1 count, 2 side, 3 index, 4 self-loop)
//   cfg_err_pin    first failing pin index
//   wtop/wright/wbottom/wleft  bidirectional routing pins
module switchbox_cfg #(
  parameter  int NTB   = 5,
  parameter  int NLR   = 4,
  parameter  int IDXW  = 3,
  localparam int CFGW  = IDXW + 3,
  localparam int NP    = 2 * NTB + 2 * NLR,
  localparam int NBITS = NP * CFGW,
  localparam int PW    = $clog2(NP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          route_en,
  input  logic          cfg_shift,
  input  logic          cfg_din,
  output logic          cfg_dout,
  input  logic          cfg_commit,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_err,
  output logic [2:0]    cfg_err_code,
  output logic [PW-1:0] cfg_err_pin,
  inout  wire [NTB-1:0] wtop,
  inout  wire [NLR-1:0] wright,
  inout  wire [NTB-1:0] wbottom,
  inout  wire [NLR-1:0] wleft
);

  localparam int CNTW = $clog2(NBITS + 2);

  typedef enum logic [1:0] {IDLE, CHECK, APPLY} state_t;

  state_t            state, state_nxt;
  logic [NBITS-1:0]  shadow, active;
  logic [CNTW-1:0]   bit_cnt;
  logic [PW-1:0]     ptr;
  logic              err_found;
  logic [2:0]        err_code_q;
  logic [PW-1:0]     err_pin_q;
  logic [CFGW-1:0]   cur_entry;
  logic [2:0]        cur_err;

  // Global pin number of the pin selected by (side, index).
  function automatic logic [PW-1:0] src_pin(input logic [2:0] side, input logic [IDXW-1:0] idx);
    int base;
    base = 0;
    case (side)
      3'd2:    base = NTB;
      3'd3:    base = NTB + NLR;
      3'd4:    base = 2 * NTB + NLR;
      default: base = 0;
    endcase
    return PW'(base + int'(idx));
  endfunction

  // Error code for one entry, in priority order: side, index range, self-loop.
  function automatic logic [2:0] entry_err(input logic [CFGW-1:0] e, input logic [PW-1:0] pin);
    logic [2:0]      side;
    logic [IDXW-1:0] idx;
    int              width;
    side  = e[2:0];
    idx   = e[CFGW-1:3];
    width = (side == 3'd1 || side == 3'd3) ? NTB : NLR;
    if (side == 3'd0)               return 3'd0;
    if (side > 3'd4)                return 3'd2;
    if (int'(idx) >= width)         return 3'd3;
    if (src_pin(side, idx) == pin)  return 3'd4;
    return 3'd0;
  endfunction

  assign cur_entry = shadow[int'(ptr) * CFGW +: CFGW];
  assign cur_err   = entry_err(cur_entry, ptr);
  assign cfg_dout  = shadow[0];
  assign cfg_busy  = (state != IDLE);

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_commit) state_nxt = CHECK;
      CHECK:   if (ptr == PW'(NP - 1)) state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      // NOTE: the wide shadow/active registers are reset too: pins must float and
      // cfg_dout must read 0 straight out of reset, so they cannot be left random.
      shadow       <= '0;
      active       <= '0;
      bit_cnt      <= '0;
      ptr          <= '0;
      err_found    <= 1'b0;
      err_code_q   <= 3'd0;
      err_pin_q    <= '0;
      cfg_done     <= 1'b0;
      cfg_err      <= 1'b0;
      cfg_err_code <= 3'd0;
      cfg_err_pin  <= '0;
    end else begin
      state    <= state_nxt;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_commit) begin
            // Bit-count error is known at commit and always reported against pin 0.
            ptr        <= '0;
            err_found  <= (bit_cnt != CNTW'(NBITS));
            err_code_q <= (bit_cnt != CNTW'(NBITS)) ? 3'd1 : 3'd0;
            err_pin_q  <= '0;
          end else if (cfg_shift) begin
            shadow <= {cfg_din, shadow[NBITS-1:1]};
            if (bit_cnt != CNTW'(NBITS + 1)) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        CHECK: begin
          // Keep only the first error in ascending pin order.
          if (!err_found && cur_err != 3'd0) begin
            err_found  <= 1'b1;
            err_code_q <= cur_err;
            err_pin_q  <= ptr;
          end
          if (ptr != PW'(NP - 1)) ptr <= ptr + 1'b1;
        end
        APPLY: begin
          bit_cnt <= '0;
          if (err_found) begin
            cfg_err      <= 1'b1;
            cfg_err_code <= err_code_q;
            cfg_err_pin  <= err_pin_q;
          end else begin
            active       <= shadow;
            cfg_done     <= 1'b1;
            cfg_err_code <= 3'd0;
            cfg_err_pin  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Pin drive: each pin copies its selected source, or floats.
  wire  [NP-1:0] pins;
  logic [NP-1:0] drv_en, drv_val;
  assign pins = {wleft, wbottom, wright, wtop};

  for (genvar k = 0; k < NP; k++) begin : g_pin
    logic [CFGW-1:0] ent;
    assign ent       = active[k * CFGW +: CFGW];
    assign drv_en[k]  = route_en && (ent[2:0] != 3'd0);
    assign drv_val[k] = pins[src_pin(ent[2:0], ent[CFGW-1:3])];
  end

  for (genvar i = 0; i < NTB; i++) begin : g_tb_side
    assign wtop[i]    = drv_en[i]           ? drv_val[i]           : 1'bz;
    assign wbottom[i] = drv_en[NTB + NLR + i] ? drv_val[NTB + NLR + i] : 1'bz;
  end

  for (genvar i = 0; i < NLR; i++) begin : g_lr_side
    assign wright[i] = drv_en[NTB + i]           ? drv_val[NTB + i]           : 1'bz;
    assign wleft[i]  = drv_en[2 * NTB + NLR + i] ? drv_val[2 * NTB + NLR + i] : 1'bz;
  end

endmodule

// File: tb/tb_switchbox_cfg.sv
// Self-checking bench for switchbox_cfg. A queue/array model of the shadow stream,
// active routing and commit latency predicts every output; a negedge process
// compares the DUT against it each cycle. Every pin carries a pull-up, so a
// floating pin reads 1; float checks drive the would-be source to 0.
module tb_switchbox_cfg;

  localparam int NTB   = 5;
  localparam int NLR   = 4;
  localparam int IDXW  = 3;
  localparam int CFGW  = IDXW + 3;
  localparam int NP    = 2 * NTB + 2 * NLR;
  localparam int NBITS = NP * CFGW;
  localparam int PW    = $clog2(NP);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          route_en, cfg_shift, cfg_din, cfg_commit;
  logic          cfg_dout, cfg_busy, cfg_done, cfg_err;
  logic [2:0]    cfg_err_code;
  logic [PW-1:0] cfg_err_pin;
  wire [NTB-1:0] wtop, wbottom;
  wire [NLR-1:0] wright, wleft;
  wire [NP-1:0]  pins_all;
  logic [NP-1:0] drv_en, drv_val;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  switchbox_cfg dut (
    .clk(clk), .rst_n(rst_n), .route_en(route_en),
    .cfg_shift(cfg_shift), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .cfg_err_code(cfg_err_code), .cfg_err_pin(cfg_err_pin),
    .wtop(wtop), .wright(wright), .wbottom(wbottom), .wleft(wleft)
  );

  assign pins_all = {wleft, wbottom, wright, wtop};

  for (genvar i = 0; i < NTB; i++) begin : g_drv_tb
    assign wtop[i]    = drv_en[i]           ? drv_val[i]           : 1'bz;
    assign wbottom[i] = drv_en[NTB + NLR + i] ? drv_val[NTB + NLR + i] : 1'bz;
    pullup pu_t (wtop[i]);
    pullup pu_b (wbottom[i]);
  end
  for (genvar i = 0; i < NLR; i++) begin : g_drv_lr
    assign wright[i] = drv_en[NTB + i]           ? drv_val[NTB + i]           : 1'bz;
    assign wleft[i]  = drv_en[2 * NTB + NLR + i] ? drv_val[2 * NTB + NLR + i] : 1'bz;
    pullup pu_r (wright[i]);
    pullup pu_l (wleft[i]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_q[$];          // shadow stream, element 0 = cfg_dout
  int         m_side[NP];
  int         m_idx[NP];
  int         m_cnt, m_left, m_code, m_pin, p_code, p_pin;
  bit         m_done, m_err;

  function automatic int pin_of(input int side, input int idx);
    case (side)
      1:       return idx;
      2:       return NTB + idx;
      3:       return NTB + NLR + idx;
      4:       return 2 * NTB + NLR + idx;
      default: return -1;
    endcase
  endfunction

  function automatic int field(input int k, input int lo, input int w);
    int v = 0;
    for (int b = 0; b < w; b++) v += int'(m_q[k * CFGW + lo + b]) << b;
    return v;
  endfunction

  task automatic model_eval(output int code, output int pin);
    code = 0; pin = 0;
    if (m_cnt != NBITS) begin code = 1; return; end
    for (int k = 0; k < NP; k++) begin
      int s, ix, w;
      s  = field(k, 0, 3);
      ix = field(k, 3, IDXW);
      w  = (s == 1 || s == 3) ? NTB : NLR;
      if (s == 0) continue;
      if (s >= 5)                  code = 2;
      else if (ix >= w)            code = 3;
      else if (pin_of(s, ix) == k) code = 4;
      if (code != 0) begin pin = k; return; end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = {};
      repeat (NBITS) m_q.push_back(1'b0);
      for (int k = 0; k < NP; k++) begin m_side[k] = 0; m_idx[k] = 0; end
      m_cnt = 0; m_left = 0; m_code = 0; m_pin = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0; m_err = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_cnt = 0;
          if (p_code != 0) begin
            m_err = 1; m_code = p_code; m_pin = p_pin;
          end else begin
            m_done = 1; m_code = 0; m_pin = 0;
            for (int k = 0; k < NP; k++) begin
              m_side[k] = field(k, 0, 3);
              m_idx[k]  = field(k, 3, IDXW);
            end
          end
        end
      end else if (cfg_commit) begin
        model_eval(p_code, p_pin);
        m_left = NP + 1;
      end else if (cfg_shift) begin
        m_q.push_back(cfg_din);
        void'(m_q.pop_front());
        if (m_cnt < NBITS + 1) m_cnt++;
      end
    end
  end

  // Expected level of pin k: follow the routing chain to a bench-driven pin or a
  // floating (pulled-up) one.
  function automatic logic exp_pin(input int k);
    int cur = k;
    for (int step = 0; step <= NP; step++) begin
      if (drv_en[cur]) return drv_val[cur];
      if (!route_en || m_side[cur] == 0) return 1'b1;
      cur = pin_of(m_side[cur], m_idx[cur]);
    end
    return 1'bx;
  endfunction

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("busy", cfg_busy, m_left > 0);
      check("done", cfg_done, m_done);
      check("err", cfg_err, m_err);
      check("err_code", cfg_err_code, m_code);
      check("err_pin", cfg_err_pin, m_pin);
      check("dout", cfg_dout, m_q[0]);
      for (int k = 0; k < NP; k++)
        if (!drv_en[k]) check($sformatf("pin%0d", k), pins_all[k], exp_pin(k));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [NBITS-1:0] put(input logic [NBITS-1:0] s, input int k,
                                           input logic [CFGW-1:0] e);
    s[k * CFGW +: CFGW] = e;
    return s;
  endfunction

  task automatic load(input logic [NBITS-1:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_din = s[i]; cfg_shift = 1'b1;
      tick();
    end
    cfg_shift = 1'b0; cfg_din = 1'b0;
  endtask

  task automatic commit_wait(input string name);
    int n = 0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    while (cfg_busy === 1'b1 && n < 100) begin n++; tick(); end
    check({name, "_busy_cycles"}, n, 19);
  endtask

  task automatic drive(input int k, input logic v);
    drv_en[k] = 1'b1; drv_val[k] = v;
    #1;
  endtask

  logic [NBITS-1:0] s_a, s_b, s_c;

  initial begin
    rst_n = 1'b1; route_en = 1'b1; cfg_shift = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0;
    drv_en = '0; drv_val = '0;

    // 1: asynchronous reset, no clock edge yet
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", cfg_busy, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_code", cfg_err_code, 0);
    check("rst_pin", cfg_err_pin, 0);
    check("rst_dout", cfg_dout, 0);
    check("rst_pins_float", pins_all, 18'h3FFFF);
    tick(); tick();
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // 2: top[0] <- bottom[2]
    s_a = put('0, 0, 6'b010_011);
    load(s_a, NBITS);
    commit_wait("s2");
    check("s2_done", cfg_done, 1);
    check("s2_err", cfg_err, 0);
    drive(11, 1'b1);
    check("s2_top0_hi", wtop[0], 1);
    drive(11, 1'b0);
    check("s2_top0_lo", wtop[0], 0);
    check("s2_others_float", pins_all, 18'h3F7FE);

    // 3: self-loop on pin 1 rejected, routing retained
    s_b = put(s_a, 1, 6'b001_001);
    load(s_b, NBITS);
    commit_wait("s3");
    check("s3_err", cfg_err, 1);
    check("s3_done", cfg_done, 0);
    check("s3_code", cfg_err_code, 4);
    check("s3_pin", cfg_err_pin, 1);
    check("s3_retained", wtop[0], 0);

    // 4: short stream, illegal side, index out of range
    load(s_a, 100);
    commit_wait("s4a");
    check("s4a_code", cfg_err_code, 1);
    check("s4a_pin", cfg_err_pin, 0);
    load(put(s_a, 3, 6'b000_101), NBITS);
    commit_wait("s4b");
    check("s4b_code", cfg_err_code, 2);
    check("s4b_pin", cfg_err_pin, 3);
    load(put(s_a, 14, 6'b100_100), NBITS);
    commit_wait("s4c");
    check("s4c_code", cfg_err_code, 3);
    check("s4c_pin", cfg_err_pin, 14);

    // 5: chain left0 <- right0 <- top0 <- bottom2, then route_en, busy shift, readback
    s_c = put(put(s_a, 5, 6'b000_001), 14, 6'b000_010);
    load(s_c, NBITS);
    commit_wait("s5a");
    check("s5a_done", cfg_done, 1);
    check("s5a_code_cleared", cfg_err_code, 0);
    check("s5a_chain", pins_all, 18'h3B7DE);
    route_en = 1'b0;
    #1 check("s5_route_off", pins_all, 18'h3F7FF);
    route_en = 1'b1;
    // Commit the same shadow again; shifts during busy must not count.
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    cfg_shift = 1'b1; cfg_din = 1'b1;
    repeat (3) tick();
    cfg_shift = 1'b0; cfg_din = 1'b0;
    repeat (20) tick();
    check("s5b_shadow_kept", cfg_dout, s_c[0]);
    for (int i = 0; i < NBITS; i++) begin
      check("s5_readback", cfg_dout, s_c[i]);
      cfg_din = s_a[i]; cfg_shift = 1'b1;
      tick();
    end
    cfg_shift = 1'b0;
    commit_wait("s5c");
    check("s5c_done", cfg_done, 1);
    check("s5c_err", cfg_err, 0);

    // 6: reset during CHECK aborts with no pulse
    load(s_c, NBITS);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    repeat (5) tick();
    check("s6_busy_before", cfg_busy, 1);
    rst_n = 1'b0;
    #1;
    check("s6_busy", cfg_busy, 0);
    check("s6_top0_float", wtop[0], 1);
    check("s6_done", cfg_done, 0);
    check("s6_err", cfg_err, 0);
    tick();
    rst_n = 1'b1;
    repeat (25) tick();
    check("s6_no_done", cfg_done, 0);
    check("s6_idle", cfg_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
